// File: rtl/demux3_reg_pkg.sv
// demux3_reg_pkg: select encoding shared by the 3:1 mux and 1:3 demux, plus select decode
package demux3_reg_pkg;
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    // s=11 aliases channel 2; the encoding constants double as channel indices
    function automatic logic [1:0] sel_to_ch(input logic [1:0] sel);
        return sel[1] ? SEL_CH2 : sel[0] ? SEL_CH1 : SEL_CH0;
    endfunction
endpackage

// File: rtl/demux3_reg_slot.sv
// demux_slot: one-entry holding register with valid/ready handshake and transfer counter
// ports: load (write din this edge), ready_out (consumer ready), valid/dout (held word),
//        cnt (completed drains, wraps), can_load (slot can take a word this edge)
module demux_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready_out,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] cnt,
    output logic             can_load
);
    logic             full_q, full_d, drain;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        drain  = full_q && ready_out;
        // a load in the same cycle as a drain keeps the slot full
        full_d = load || (full_q && !ready_out);
        data_d = load ? din : data_q;
        cnt_d  = cnt_q + CNT_W'(drain);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
    assign can_load = !full_q || ready_out;
    assign valid    = full_q;
    assign dout     = data_q;
    assign cnt      = cnt_q;
endmodule

// File: rtl/demux3_reg.sv
// demux3_reg: registered 1:3 demultiplexer with per-channel valid/ready holding slots
// ports: d/s/in_valid/in_ready producer side; y_k/v_k/r_k consumer side per channel;
//        cnt_k completed transfers per channel
module demux3_reg
    import demux3_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);
    logic [1:0]       tgt;
    logic [2:0]       can_load, load, r, v;
    logic [WIDTH-1:0] y   [3];
    logic [CNT_W-1:0] cnt [3];
    assign r = {r2, r1, r0};
    // in_ready looks only at the targeted slot so stalled channels never block others
    always_comb begin
        tgt      = sel_to_ch(s);
        in_ready = (tgt == 2'd2) ? can_load[2] : (tgt == 2'd1) ? can_load[1] : can_load[0];
        load     = {3{in_valid && in_ready}} & (3'b001 << tgt);
    end
    for (genvar i = 0; i < 3; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .din      (d),
            .ready_out(r[i]),
            .valid    (v[i]),
            .dout     (y[i]),
            .cnt      (cnt[i]),
            .can_load (can_load[i])
        );
    end
    assign {v2, v1, v0} = v;
    assign y0   = y[0];
    assign y1   = y[1];
    assign y2   = y[2];
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
endmodule

// File: tb/tb_demux3_reg.sv
// tb_demux3_reg: directed and random stimulus checked against a per-channel occupancy model
module tb_demux3_reg;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready;
    logic [7:0] d;
    logic [1:0] s;
    logic [7:0] y0, y1, y2, cnt0, cnt1, cnt2;
    logic       v0, v1, v2, r0, r1, r2;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         m_full [3];
    logic [7:0] m_data [3];
    int         m_cnt  [3];

    demux3_reg #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .v0(v0), .v1(v1), .v2(v2),
        .r0(r0), .r1(r1), .r2(r2), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tgt_of(input logic [1:0] sv);
        return (sv >= 2'd2) ? 2 : int'(sv);
    endfunction

    task automatic check_outputs();
        logic [7:0] ys [3];
        logic [7:0] cs [3];
        logic [2:0] vs;
        ys = '{y0, y1, y2};
        cs = '{cnt0, cnt1, cnt2};
        vs = {v2, v1, v0};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("v%0d", k), vs[k], m_full[k]);
            if (m_full[k]) chk($sformatf("y%0d", k), ys[k], m_data[k]);
            chk($sformatf("cnt%0d", k), cs[k], m_cnt[k] % 256);
        end
    endtask

    // one clock: drive, check in_ready, advance the model by the handshake rules, check outputs
    task automatic step(input bit rs, input bit iv, input logic [1:0] sv,
                        input logic [7:0] dv, input logic [2:0] rv);
        int t;
        bit rdy;
        reset = rs; in_valid = iv; s = sv; d = dv; {r2, r1, r0} = rv;
        t   = tgt_of(sv);
        rdy = !m_full[t] || rv[t];
        #1 chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (rs) begin
            for (int k = 0; k < 3; k++) begin
                m_full[k] = 0;
                m_data[k] = 8'h00;
                m_cnt[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++)
                if (m_full[k] && rv[k]) begin
                    m_full[k] = 0;
                    m_cnt[k]  = m_cnt[k] + 1;
                end
            if (iv && rdy) begin
                m_full[t] = 1;
                m_data[t] = dv;
            end
        end
        #1 check_outputs();
    endtask

    initial begin
        step(1, 0, 2'b00, 8'h00, 3'b111);
        chk("rst_y0", y0, 8'h00);
        chk("rst_y1", y1, 8'h00);
        chk("rst_y2", y2, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 2'(i), 8'h00, 3'b111);

        step(0, 1, 2'b00, 8'hA5, 3'b111);
        step(0, 1, 2'b01, 8'h3C, 3'b111);
        step(0, 1, 2'b10, 8'hF0, 3'b111);
        chk("route_y2_f0", y2, 8'hF0);
        step(0, 1, 2'b11, 8'h0F, 3'b111);
        chk("route_y2_0f", y2, 8'h0F);
        step(0, 0, 2'b00, 8'h00, 3'b111);
        chk("route_cnt0", cnt0, 8'd1);
        chk("route_cnt1", cnt1, 8'd1);
        chk("route_cnt2", cnt2, 8'd2);

        step(0, 1, 2'b01, 8'h11, 3'b101);
        step(0, 1, 2'b01, 8'h22, 3'b101);
        chk("bp_hold_y1", y1, 8'h11);
        step(0, 1, 2'b00, 8'h33, 3'b101);
        chk("bp_side_y0", y0, 8'h33);
        step(0, 1, 2'b01, 8'h22, 3'b111);
        chk("bp_y1_22", y1, 8'h22);
        step(0, 0, 2'b00, 8'h00, 3'b111);

        step(1, 0, 2'b00, 8'h00, 3'b111);
        for (int i = 0; i < 10; i++) step(0, 1, 2'b10, 8'($urandom), 3'b111);
        step(0, 0, 2'b00, 8'h00, 3'b111);
        chk("stream_cnt2", cnt2, 8'd10);

        step(1, 0, 2'b00, 8'h00, 3'b111);
        for (int i = 0; i < 256; i++) step(0, 1, 2'b00, 8'(i), 3'b111);
        step(0, 0, 2'b00, 8'h00, 3'b111);
        chk("wrap_256", cnt0, 8'd0);
        step(0, 1, 2'b00, 8'h5A, 3'b111);
        step(0, 0, 2'b00, 8'h00, 3'b111);
        chk("wrap_257", cnt0, 8'd1);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
                 8'($urandom), 3'($urandom));

        step(0, 1, 2'b00, 8'hC0, 3'b000);
        step(0, 1, 2'b01, 8'hC1, 3'b000);
        step(0, 1, 2'b10, 8'hC2, 3'b000);
        step(1, 1, 2'b00, 8'hAA, 3'b000);
        chk("mid_rst_v", {v2, v1, v0}, 3'b000);
        chk("mid_rst_y0", y0, 8'h00);
        chk("mid_rst_y1", y1, 8'h00);
        chk("mid_rst_y2", y2, 8'h00);
        step(0, 0, 2'b00, 8'h00, 3'b111);
        chk("mid_rst_lost", {v2, v1, v0}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
